// File: rtl/conv_encoder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : conv_encoder_ctrl
//  Purpose  : Sequencer for the convolutional encoder datapath. In encode
//             mode it streams frame bits into the encoder, appends K-1 zero
//             tail bits and emits registered code symbols with valid/ready
//             backpressure. In table mode it walks the radix-4 transition
//             table (4*2^(K-1) entries) and streams each entry out.
//  Ports    : clk, rst                     - clock, synchronous active-high reset
//             i_start/i_mode/i_k/i_rate    - operation request and config
//             i_bit/i_bit_valid/i_bit_last - frame bit stream, o_bit_ready
//             o_ce_en/o_ce_mode/o_ce_bit/o_ce_rst_n - encoder control pins
//             i_ce_data/i_ce_mux           - encoder symbol / table entry
//             o_sym*/i_sym_ready           - code-symbol stream
//             o_tbl*/i_tbl_ready           - table-entry stream
//             o_busy/o_done/o_err          - status
//  Revision : 1.0 - initial release
// ============================================================================
module conv_encoder_ctrl #(
    parameter int MAX_CONSTRAINT_LENGTH = 9,
    parameter int MAX_CODE_RATE         = 3,
    parameter int TBL_W                 = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_mode,
    input  logic [3:0]               i_k,
    input  logic [1:0]               i_rate,
    input  logic                     i_bit,
    input  logic                     i_bit_valid,
    input  logic                     i_bit_last,
    output logic                     o_bit_ready,
    output logic                     o_ce_en,
    output logic                     o_ce_mode,
    output logic                     o_ce_bit,
    output logic                     o_ce_rst_n,
    input  logic [MAX_CODE_RATE-1:0] i_ce_data,
    input  logic [TBL_W-1:0]         i_ce_mux,
    output logic [MAX_CODE_RATE-1:0] o_sym,
    output logic                     o_sym_valid,
    output logic                     o_sym_last,
    input  logic                     i_sym_ready,
    output logic [TBL_W-1:0]         o_tbl,
    output logic                     o_tbl_valid,
    output logic                     o_tbl_last,
    input  logic                     i_tbl_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    // Entry counter must hold 4*2^(K-1) = 2^(K+1) entries for the largest K.
    localparam int                  c_ent_w = MAX_CONSTRAINT_LENGTH + 2;
    localparam logic [c_ent_w-1:0]  c_one   = c_ent_w'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_ENC_DATA = 3'd2,
        S_ENC_TAIL = 3'd3,
        S_TBL_SCAN = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_next;

    logic                     r_mode;
    logic [3:0]               r_k;
    logic [1:0]               r_rate;
    logic [3:0]               r_tail;
    logic [c_ent_w-1:0]       r_ent;

    logic [MAX_CODE_RATE-1:0] r_sym;
    logic                     r_sym_valid;
    logic                     r_sym_last;
    logic [TBL_W-1:0]         r_tbl;
    logic                     r_tbl_valid;
    logic                     r_tbl_last;
    logic                     r_ce_rst_n;
    logic                     r_done;
    logic                     r_err;

    logic                     w_sym_free;
    logic                     w_tbl_free;
    logic                     w_cfg_ok;
    logic [c_ent_w-1:0]       w_ent_last_idx;
    logic [MAX_CODE_RATE-1:0] w_sym_in;

    logic                     w_ce_en;
    logic                     w_ce_bit;
    logic                     w_bit_ready;
    logic                     w_sym_load;
    logic                     w_sym_last_in;
    logic                     w_tbl_load;
    logic                     w_tbl_last_in;
    logic                     w_start_ok;
    logic                     w_start_bad;
    logic                     w_done;

    assign w_sym_free = !r_sym_valid || i_sym_ready;
    assign w_tbl_free = !r_tbl_valid || i_tbl_ready;

    // Rate only matters for encode; table scans accept any rate field.
    assign w_cfg_ok = (i_k >= 4'd3) && (int'(i_k) <= MAX_CONSTRAINT_LENGTH) &&
                      (i_mode || (((i_rate == 2'd2) || (i_rate == 2'd3)) &&
                                  (int'(i_rate) <= MAX_CODE_RATE)));

    assign w_ent_last_idx = (c_one << (r_k + 4'd1)) - c_one;

    // Encoder outputs above the configured rate are not part of the code.
    always_comb begin
        w_sym_in = i_ce_data;
        for (int b = 0; b < MAX_CODE_RATE; b++) begin
            if (b >= int'(r_rate)) begin
                w_sym_in[b] = 1'b0;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_ce_en       = 1'b0;
        w_ce_bit      = 1'b0;
        w_bit_ready   = 1'b0;
        w_sym_load    = 1'b0;
        w_sym_last_in = 1'b0;
        w_tbl_load    = 1'b0;
        w_tbl_last_in = 1'b0;
        w_start_ok    = 1'b0;
        w_start_bad   = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_cfg_ok) begin
                        w_start_ok = 1'b1;
                        w_next     = S_CLEAR;
                    end else begin
                        w_start_bad = 1'b1;
                    end
                end
            end

            S_CLEAR: begin
                w_next = r_mode ? S_TBL_SCAN : S_ENC_DATA;
            end

            S_ENC_DATA: begin
                w_bit_ready = w_sym_free;
                w_ce_bit    = i_bit;
                w_ce_en     = i_bit_valid && w_sym_free;
                w_sym_load  = w_ce_en;
                if (w_ce_en && i_bit_last) begin
                    w_next = S_ENC_TAIL;
                end
            end

            S_ENC_TAIL: begin
                // Zero tail bits flush the shift register back to state 0.
                w_ce_en       = w_sym_free;
                w_sym_load    = w_ce_en;
                w_sym_last_in = (r_tail == 4'd1);
                if (w_ce_en && (r_tail == 4'd1)) begin
                    w_next = S_DONE;
                end
            end

            S_TBL_SCAN: begin
                w_ce_en       = w_tbl_free;
                w_tbl_load    = w_ce_en;
                w_tbl_last_in = (r_ent == w_ent_last_idx);
                if (w_ce_en && (r_ent == w_ent_last_idx)) begin
                    w_next = S_DONE;
                end
            end

            S_DONE: begin
                if (r_mode ? w_tbl_free : w_sym_free) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_k         <= 4'd0;
            r_rate      <= 2'd0;
            r_tail      <= 4'd0;
            r_ent       <= '0;
            r_sym       <= '0;
            r_sym_valid <= 1'b0;
            r_sym_last  <= 1'b0;
            r_tbl       <= '0;
            r_tbl_valid <= 1'b0;
            r_tbl_last  <= 1'b0;
            r_ce_rst_n  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            // Registered so the encoder clear lines up exactly with CLEAR.
            r_ce_rst_n <= (w_next != S_CLEAR);
            r_done     <= w_done;
            r_err      <= w_start_bad;

            if (w_start_ok) begin
                r_mode <= i_mode;
                r_k    <= i_k;
                r_rate <= i_rate;
            end

            if (r_state == S_CLEAR) begin
                r_ent  <= '0;
                r_tail <= 4'd0;
            end else if ((r_state == S_ENC_DATA) && w_ce_en && i_bit_last) begin
                r_tail <= r_k - 4'd1;
            end else if ((r_state == S_ENC_TAIL) && w_ce_en) begin
                r_tail <= r_tail - 4'd1;
            end

            if (w_tbl_load) begin
                r_ent <= r_ent + c_one;
            end

            if (w_sym_load) begin
                r_sym       <= w_sym_in;
                r_sym_valid <= 1'b1;
                r_sym_last  <= w_sym_last_in;
            end else if (i_sym_ready) begin
                r_sym_valid <= 1'b0;
                r_sym_last  <= 1'b0;
            end

            if (w_tbl_load) begin
                r_tbl       <= i_ce_mux;
                r_tbl_valid <= 1'b1;
                r_tbl_last  <= w_tbl_last_in;
            end else if (i_tbl_ready) begin
                r_tbl_valid <= 1'b0;
                r_tbl_last  <= 1'b0;
            end
        end
    end

    assign o_bit_ready = w_bit_ready;
    assign o_ce_en     = w_ce_en;
    assign o_ce_bit    = w_ce_bit;
    assign o_ce_mode   = r_mode && (r_state != S_IDLE);
    assign o_ce_rst_n  = r_ce_rst_n;
    assign o_sym       = r_sym;
    assign o_sym_valid = r_sym_valid;
    assign o_sym_last  = r_sym_last;
    assign o_tbl       = r_tbl;
    assign o_tbl_valid = r_tbl_valid;
    assign o_tbl_last  = r_tbl_last;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_conv_encoder_ctrl
//  Purpose  : Self-checking bench for conv_encoder_ctrl. A behavioural model
//             of the attached encoder (K=3 taps 7/5 plus a third tap 6 for
//             rate 3, and a table counter) drives i_ce_data / i_ce_mux.
//             Encode frames come from a table of hand-computed symbol lists.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_encoder_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0, i_mode = 1'b0;
    logic [3:0]  i_k = 4'd0;
    logic [1:0]  i_rate = 2'd0;
    logic        i_bit = 1'b0, i_bit_valid = 1'b0, i_bit_last = 1'b0;
    logic        o_bit_ready, o_ce_en, o_ce_mode, o_ce_bit, o_ce_rst_n;
    logic [2:0]  i_ce_data;
    logic [15:0] i_ce_mux;
    logic [2:0]  o_sym;
    logic        o_sym_valid, o_sym_last;
    logic        i_sym_ready = 1'b0;
    logic [15:0] o_tbl;
    logic        o_tbl_valid, o_tbl_last;
    logic        i_tbl_ready = 1'b0;
    logic        o_busy, o_done, o_err;

    always #5 clk = ~clk;

    conv_encoder_ctrl #(
        .MAX_CONSTRAINT_LENGTH(9),
        .MAX_CODE_RATE(3),
        .TBL_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .i_mode(i_mode), .i_k(i_k), .i_rate(i_rate),
        .i_bit(i_bit), .i_bit_valid(i_bit_valid), .i_bit_last(i_bit_last),
        .o_bit_ready(o_bit_ready),
        .o_ce_en(o_ce_en), .o_ce_mode(o_ce_mode), .o_ce_bit(o_ce_bit), .o_ce_rst_n(o_ce_rst_n),
        .i_ce_data(i_ce_data), .i_ce_mux(i_ce_mux),
        .o_sym(o_sym), .o_sym_valid(o_sym_valid), .o_sym_last(o_sym_last), .i_sym_ready(i_sym_ready),
        .o_tbl(o_tbl), .o_tbl_valid(o_tbl_valid), .o_tbl_last(o_tbl_last), .i_tbl_ready(i_tbl_ready),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    // ---------------- attached encoder model ----------------
    logic [7:0] enc_h;   // enc_h[0] = most recent input bit
    logic [9:0] enc_c;   // table walk counter: {state, input}

    function automatic logic [15:0] tbl_entry(input logic [9:0] c);
        return {c[1:0], c[9:2], c[2:0] ^ c[5:3], c[8:6]};
    endfunction

    always @(posedge clk) begin
        if (!o_ce_rst_n) begin
            enc_h <= 8'd0;
            enc_c <= 10'd0;
        end else if (o_ce_en) begin
            if (o_ce_mode) enc_c <= enc_c + 10'd1;
            else           enc_h <= {enc_h[6:0], o_ce_bit};
        end
    end

    assign i_ce_data = {o_ce_bit ^ enc_h[0], o_ce_bit ^ enc_h[1], o_ce_bit ^ enc_h[0] ^ enc_h[1]};
    assign i_ce_mux  = tbl_entry(enc_c);

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, o_bit_ready, o_ce_en, o_ce_mode, o_ce_bit, o_ce_rst_n, o_sym, o_sym_valid,
                o_sym_last, o_tbl, o_tbl_valid, o_tbl_last, o_busy, o_done, o_err};
    endfunction

    // ---------------- encode frame vectors ----------------
    typedef struct {
        logic [3:0]  k;
        logic [1:0]  rate;
        logic [7:0]  bits;      // bit i of the frame at index i
        int          nbits;
        logic [3:0]  rdy_pat;   // i_sym_ready per cycle, index cyc%4
        logic [3:0]  vld_pat;   // i_bit_valid per cycle, index cyc%4
        bit          poke;      // invalid i_start while in ENC_DATA
        logic [29:0] exp;       // symbol i at exp[3*i +: 3]
        int          nsym;
    } frame_vec_t;

    frame_vec_t frames [0:5];

    task automatic run_frame(input int f);
        frame_vec_t v;
        int  idx, ns, last_hs, done_cyc;
        bit  held_v, err_seen;
        logic [2:0] held, e;
        logic held_last;
        v = frames[f];
        idx = 0; ns = 0; last_hs = -100; done_cyc = -1;
        held_v = 1'b0; err_seen = 1'b0; held = 3'd0; held_last = 1'b0;

        @(posedge clk); #1;
        i_k = v.k; i_rate = v.rate; i_mode = 1'b0; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        chk($sformatf("f%0d_clear_rst_n", f), o_ce_rst_n, 1'b0);

        for (int cyc = 0; cyc < 200; cyc++) begin
            @(posedge clk); #1;
            i_sym_ready = v.rdy_pat[cyc % 4];
            if (idx < v.nbits) begin
                i_bit_valid = v.vld_pat[cyc % 4];
                i_bit       = v.bits[idx];
                i_bit_last  = (idx == v.nbits - 1);
            end else begin
                i_bit_valid = 1'b0; i_bit = 1'b0; i_bit_last = 1'b0;
            end
            if (v.poke && cyc == 0) begin
                i_start = 1'b1; i_k = 4'd2;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
            if (held_v)
                chk($sformatf("f%0d_sym_hold", f), {o_sym_valid, o_sym_last, o_sym},
                    {1'b1, held_last, held});
            held_v    = o_sym_valid && !i_sym_ready;
            held      = o_sym;
            held_last = o_sym_last;
            if (i_bit_valid && o_bit_ready) idx++;
            if (o_sym_valid && i_sym_ready) begin
                if (ns < v.nsym) begin
                    e = v.exp[3*ns +: 3];
                    chk($sformatf("f%0d_sym%0d", f, ns), o_sym, e);
                end
                chk($sformatf("f%0d_last%0d", f, ns), o_sym_last, (ns == v.nsym - 1));
                ns++;
                last_hs = cyc;
            end
            if (o_err) err_seen = 1'b1;
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
        end
        i_bit_valid = 1'b0; i_bit_last = 1'b0; i_start = 1'b0;
        chk($sformatf("f%0d_nsym", f), ns, v.nsym);
        chk($sformatf("f%0d_done_lat", f), done_cyc - last_hs, 1);
        chk($sformatf("f%0d_no_err", f), err_seen, 1'b0);
    endtask

    task automatic run_scan(input logic [3:0] k, input logic [3:0] pat, input int exp_n);
        int n, bad, badlast, badhold, done_cyc, last_cyc;
        logic [15:0] first, held;
        bit held_v;
        n = 0; bad = 0; badlast = 0; badhold = 0; done_cyc = -1; last_cyc = -100;
        first = 16'hFFFF; held = 16'h0; held_v = 1'b0;

        @(posedge clk); #1;
        i_k = k; i_rate = 2'd0; i_mode = 1'b1; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        chk($sformatf("scan%0d_clear", k), {o_ce_rst_n, o_ce_mode, o_busy}, 3'b011);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            i_tbl_ready = pat[cyc % 4];
            @(negedge clk);
            if (held_v && (!o_tbl_valid || o_tbl !== held)) badhold++;
            held_v = o_tbl_valid && !i_tbl_ready;
            held   = o_tbl;
            if (o_tbl_valid && i_tbl_ready) begin
                if (n == 0) first = o_tbl;
                if (o_tbl !== tbl_entry(10'(n))) bad++;
                if (o_tbl_last !== (n == exp_n - 1)) badlast++;
                n++;
                last_cyc = cyc;
            end
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
        end
        chk($sformatf("scan%0d_count", k), n, exp_n);
        chk($sformatf("scan%0d_first", k), first, 16'h0000);
        chk($sformatf("scan%0d_entries_bad", k), bad, 0);
        chk($sformatf("scan%0d_last_bad", k), badlast, 0);
        chk($sformatf("scan%0d_hold_bad", k), badhold, 0);
        chk($sformatf("scan%0d_done_lat", k), done_cyc - last_cyc, 1);
        chk($sformatf("scan%0d_idle_at_done", k), {o_busy, o_ce_mode}, 2'b00);
        @(negedge clk);
        chk($sformatf("scan%0d_done_pulse", k), o_done, 1'b0);
    endtask

    task automatic try_bad(input string nm, input logic mode, input logic [3:0] k,
                           input logic [1:0] rate);
        @(posedge clk); #1;
        i_mode = mode; i_k = k; i_rate = rate; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        chk({nm, "_err"}, {o_err, o_busy}, 2'b10);
        @(negedge clk);
        chk({nm, "_err_pulse"}, {o_err, o_busy}, 2'b00);
    endtask

    initial begin
        // K=3 rate 2, bits 1,0,1,1 -> 3,1,0,2 + tail 2,3
        frames[0] = '{k: 4'd3, rate: 2'd2, bits: 8'b0000_1101, nbits: 4, rdy_pat: 4'b1111,
                      vld_pat: 4'b1111, poke: 1'b0,
                      exp: {12'd0, 3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd3}, nsym: 6};
        // same frame, ready toggling 1,0,0,1
        frames[1] = '{k: 4'd3, rate: 2'd2, bits: 8'b0000_1101, nbits: 4, rdy_pat: 4'b1001,
                      vld_pat: 4'b1111, poke: 1'b0,
                      exp: {12'd0, 3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd3}, nsym: 6};
        // rate 3 with gaps in i_bit_valid -> 7,5,4,2,6,3
        frames[2] = '{k: 4'd3, rate: 2'd3, bits: 8'b0000_1101, nbits: 4, rdy_pat: 4'b1111,
                      vld_pat: 4'b0101, poke: 1'b0,
                      exp: {12'd0, 3'd3, 3'd6, 3'd2, 3'd4, 3'd5, 3'd7}, nsym: 6};
        // K=4 rate 3, bits 1,1 -> 7,2 + tail 6,3,0
        frames[3] = '{k: 4'd4, rate: 2'd3, bits: 8'b0000_0011, nbits: 2, rdy_pat: 4'b0111,
                      vld_pat: 4'b1111, poke: 1'b0,
                      exp: {15'd0, 3'd0, 3'd3, 3'd6, 3'd2, 3'd7}, nsym: 5};
        // single-bit frame, invalid i_start poked mid-frame -> 3 + tail 1,3
        frames[4] = '{k: 4'd3, rate: 2'd2, bits: 8'b0000_0001, nbits: 1, rdy_pat: 4'b1111,
                      vld_pat: 4'b1111, poke: 1'b1,
                      exp: {21'd0, 3'd3, 3'd1, 3'd3}, nsym: 3};
        // repeat of the first frame, started right after the previous o_done
        frames[5] = frames[0];

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", all_outs(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_release_rst_n", {o_ce_rst_n, o_busy}, 2'b10);

        // reset in the middle of ENC_DATA
        @(posedge clk); #1;
        i_k = 4'd3; i_rate = 2'd2; i_mode = 1'b0; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        i_bit_valid = 1'b1; i_bit = 1'b1; i_bit_last = 1'b0; i_sym_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outs", all_outs(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        i_bit_valid = 1'b0; i_bit = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_release", {o_ce_rst_n, o_busy, o_done, o_sym_last}, 4'b1000);
        begin
            int done_cnt;
            done_cnt = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (o_done || o_busy) done_cnt++;
            end
            chk("midrst_no_done", done_cnt, 0);
        end

        // invalid configurations
        try_bad("k2_enc",   1'b0, 4'd2,  2'd2);
        try_bad("k10_enc",  1'b0, 4'd10, 2'd2);
        try_bad("rate1",    1'b0, 4'd3,  2'd1);
        try_bad("k2_scan",  1'b1, 4'd2,  2'd0);

        // encode frames, back to back
        for (int f = 0; f < 6; f++) run_frame(f);

        // table scans
        run_scan(4'd3, 4'b1111, 16);
        run_scan(4'd4, 4'b0110, 32);
        run_scan(4'd9, 4'b1011, 1024);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_encoder_ctrl.md
Name: conv_encoder_ctrl

Overview:
Sequencer for the convolutional encoder datapath; the controller drives the encoder's enable, mode, input-bit and reset pins. In encode mode it streams frame bits into the encoder, appends K-1 zero tail bits, and emits registered code symbols with valid/ready backpressure. In decode mode it scans the radix-4 transition table (4*2^(K-1) entries) for trellis/BMU setup and streams each 16-bit entry out. It sits between the frame source/sink and the encoder instance.

Parameters:
MAX_CONSTRAINT_LENGTH, 9, largest supported K (state register width = MAX_CONSTRAINT_LENGTH-1)
MAX_CODE_RATE, 3, encoder output bits per input bit
TBL_W, 16, width of one transition-table entry (2b input, 8b state, 2x3b outputs)

Ports:
clk  in  1  system clock
rst  in  1  reset
i_start  in  1  one-cycle start pulse, sampled only in IDLE
i_mode  in  1  0 = encode frame, 1 = table scan; latched on start
i_k  in  4  constraint length 3..9; latched on start
i_rate  in  2  2 or 3; latched on start
i_bit / i_bit_valid / i_bit_last  in  1/1/1  input frame stream
o_bit_ready  out  1  frame bit accepted when valid&ready
o_ce_en  out  1  to encoder en_ce
o_ce_mode  out  1  to encoder i_mode_sel
o_ce_bit  out  1  to encoder i_encoder_bit
o_ce_rst_n  out  1  to encoder rst (active-low state clear)
i_ce_data  in  MAX_CODE_RATE  from encoder o_encoder_data
i_ce_mux  in  TBL_W  from encoder o_mux
o_sym / o_sym_valid / o_sym_last  out  MAX_CODE_RATE/1/1  code-symbol stream
i_sym_ready  in  1  symbol sink ready
o_tbl / o_tbl_valid / o_tbl_last  out  TBL_W/1/1  table-entry stream
i_tbl_ready  in  1  table sink ready
o_busy  out  1  high in any non-IDLE state
o_done  out  1  one-cycle pulse at operation end
o_err  out  1  one-cycle pulse on start with invalid config

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk and reset port is rst.
- Reset: all outputs are 0, including o_ce_rst_n (holds the encoder cleared). State goes to IDLE. Reset mid-operation abandons the frame with no o_done and no o_sym_last.
- States: IDLE -> CLEAR -> (ENC_DATA -> ENC_TAIL | TBL_SCAN) -> DONE -> IDLE.
- IDLE: o_ce_rst_n=1, o_ce_en=0. On i_start, if i_k is not in 3..9, or i_rate is not in {2,3} for encode, pulse o_err and stay in IDLE. Otherwise latch the config and go to CLEAR. i_start outside IDLE is ignored.
- CLEAR: exactly 1 cycle with o_ce_rst_n=0, zeroing the encoder shift register and scan counters. o_ce_mode = latched mode from CLEAR onward until IDLE.
- Slot free: the symbol output is free when !o_sym_valid || i_sym_ready. The table output is free when !o_tbl_valid || i_tbl_ready.
- ENC_DATA:
  - o_bit_ready = slot free.
  - o_ce_en = i_bit_valid & o_bit_ready, and o_ce_bit = i_bit (combinational).
  - On an accepted bit, o_sym is loaded next edge from i_ce_data. Bit MAX_CODE_RATE-1 is forced to 0 when rate=2. o_sym_valid is set.
  - Latency is 1 cycle from bit acceptance to symbol valid; throughput is 1 bit/cycle when unstalled.
  - If a symbol is consumed and no new bit is accepted, o_sym_valid clears.
  - An accepted bit with i_bit_last goes to ENC_TAIL with tail counter = K-1.
- ENC_TAIL:
  - o_bit_ready=0 and o_ce_bit=0.
  - o_ce_en = slot free. Each enabled cycle produces one symbol and decrements the tail counter.
  - The symbol produced at counter=1 carries o_sym_last=1. Then go to DONE.
- TBL_SCAN:
  - o_ce_en = table slot free. On enable, o_tbl <= i_ce_mux and o_tbl_valid=1.
  - The entry counter (11 bits) counts to 4*2^(K-1) entries (16 for K=3, 1024 for K=9). The final entry carries o_tbl_last=1, then go to DONE.
  - The encoder's internal counters advance only when enabled. Entries with state >= 2^(K-1) are never emitted.
- DONE: wait until the last symbol/entry is consumed (valid=0 or ready=1). Then pulse o_done for one cycle, set o_ce_en=0, and return to IDLE.
- Stall: while the sink is not ready, o_sym/o_tbl and the valid/last flags hold stable and the encoder is not enabled.
- Simultaneous i_bit_last and sink stall: the bit is not accepted, and the ENC_DATA state holds.

Test Plan:
1. Reset: assert rst 3 cycles mid-ENC_DATA -> all outputs 0, o_ce_rst_n=0, state IDLE. Release -> o_ce_rst_n=1 next cycle, no o_done.
2. Encode with attached encoder, K=3, rate 2, polys 7/5, bits 1,0,1,1 (last on 4th), sink always ready -> o_sym = 3,1,0,2 then tail 2,3. o_sym_last on the 6th symbol, o_done 1 cycle after.
3. Same frame with i_sym_ready toggled 1,0,0,1,... -> identical symbol sequence, symbols held stable while stalled, no duplicates or drops.
4. Table scan K=3 -> exactly 16 entries, first entry 0x0000, o_tbl_last on the 16th, o_done pulse. Repeat with K=9 -> 1024 entries.
5. i_start with i_k=2 -> o_err pulse, o_busy stays 0. i_start during ENC_DATA -> ignored, frame unaffected.
6. Back-to-back frames: second start 1 cycle after o_done -> CLEAR re-zeros the encoder, and the second frame's symbols match an isolated run.
